// File: rtl/oup_ulpi_phy_responder_if.sv
// rtl/oup_ulpi_phy_responder_if.sv - ULPI bus plus PHY-side packet, line-state and register signals
interface oup_ulpi_phy_responder_if;
    logic [7:0] ulpi_data_i;
    logic [7:0] ulpi_data_o;
    logic       ulpi_dir_o;
    logic       ulpi_stp_i;
    logic       ulpi_nxt_o;
    logic       tx_start_o;
    logic [3:0] tx_pid_o;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_end_o;
    logic       tx_abort_o;
    logic [7:0] rx_data_i;
    logic       rx_valid_i;
    logic       rx_last_i;
    logic       rx_ready_o;
    logic [1:0] linestate_i;
    logic [1:0] vbus_state_i;
    logic       id_i;
    logic [7:0] func_ctrl_o;
    logic [7:0] iface_ctrl_o;
    logic [7:0] otg_ctrl_o;

    modport master (
        input  ulpi_data_i, ulpi_stp_i, rx_data_i, rx_valid_i, rx_last_i,
               linestate_i, vbus_state_i, id_i,
        output ulpi_data_o, ulpi_dir_o, ulpi_nxt_o, tx_start_o, tx_pid_o,
               tx_data_o, tx_valid_o, tx_end_o, tx_abort_o, rx_ready_o,
               func_ctrl_o, iface_ctrl_o, otg_ctrl_o
    );

    modport slave (
        output ulpi_data_i, ulpi_stp_i, rx_data_i, rx_valid_i, rx_last_i,
               linestate_i, vbus_state_i, id_i,
        input  ulpi_data_o, ulpi_dir_o, ulpi_nxt_o, tx_start_o, tx_pid_o,
               tx_data_o, tx_valid_o, tx_end_o, tx_abort_o, rx_ready_o,
               func_ctrl_o, iface_ctrl_o, otg_ctrl_o
    );
endinterface

// File: rtl/oup_ulpi_phy_responder.sv
// rtl/oup_ulpi_phy_responder.sv - PHY-side ULPI responder: TXCMD decode, register map, RX CMD and RX packet streaming
module oup_ulpi_phy_responder #(
    parameter logic [15:0] VENDOR_ID  = 16'h0424,
    parameter logic [15:0] PRODUCT_ID = 16'h0009
) (
    input  logic                     ulpi_clk_i,
    input  logic                     rst_i,
    oup_ulpi_phy_responder_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, CMD_ACK, REGW_DATA, REGW_STP, REGR_TURN, REGR_DATA,
        TX_DATA, RX_TURN, RX_DATA, RXCMD_TURN, RXCMD_DATA, TURN_BACK
    } state_t;

    state_t     state, state_n;
    logic [7:0] cmd_q, cmd_n;
    logic [7:0] wdata_q, wdata_n;
    logic [7:0] data_q, data_n;
    logic       dir_q, dir_n;
    logic       nxt_q, nxt_n;
    logic       tx_start_q, tx_start_n;
    logic [3:0] tx_pid_q, tx_pid_n;
    logic [7:0] tx_data_q, tx_data_n;
    logic       tx_valid_q, tx_valid_n;
    logic       tx_end_q, tx_end_n;
    logic       tx_abort_q, tx_abort_n;
    logic       rx_done_q, rx_done_n;
    logic [4:0] last_rx_q, last_rx_n;
    logic [4:0] cur_rx;
    logic       commit;
    logic [7:0] func_q, iface_q, otg_q, scratch_q;
    logic [7:0] rd_val;

    assign cur_rx = {bus.id_i, bus.vbus_state_i, bus.linestate_i};

    // Set/clear aliases read back the base register.
    always_comb begin
        rd_val = 8'h00;
        case (cmd_q[5:0])
            6'h00:               rd_val = VENDOR_ID[7:0];
            6'h01:               rd_val = VENDOR_ID[15:8];
            6'h02:               rd_val = PRODUCT_ID[7:0];
            6'h03:               rd_val = PRODUCT_ID[15:8];
            6'h04, 6'h05, 6'h06: rd_val = func_q;
            6'h07, 6'h08, 6'h09: rd_val = iface_q;
            6'h0A, 6'h0B, 6'h0C: rd_val = otg_q;
            6'h16, 6'h17, 6'h18: rd_val = scratch_q;
            default:             rd_val = 8'h00;
        endcase
    end

    always_comb begin
        state_n    = state;
        cmd_n      = cmd_q;
        wdata_n    = wdata_q;
        last_rx_n  = last_rx_q;
        rx_done_n  = rx_done_q;
        dir_n      = dir_q;
        nxt_n      = 1'b0;
        data_n     = 8'h00;
        tx_start_n = 1'b0;
        tx_pid_n   = tx_pid_q;
        tx_data_n  = tx_data_q;
        tx_valid_n = 1'b0;
        tx_end_n   = 1'b0;
        tx_abort_n = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                dir_n = 1'b0;
                // A PHY-initiated turnaround beats a TXCMD on the same edge; the link retries.
                if (bus.rx_valid_i) begin
                    state_n = RX_TURN;
                    dir_n   = 1'b1;
                    nxt_n   = 1'b1;
                end else if (last_rx_q != cur_rx) begin
                    state_n = RXCMD_TURN;
                    dir_n   = 1'b1;
                end else if (bus.ulpi_data_i[7:6] != 2'b00) begin
                    state_n = CMD_ACK;
                    cmd_n   = bus.ulpi_data_i;
                    nxt_n   = 1'b1;
                    if (bus.ulpi_data_i[7:6] == 2'b01) begin
                        tx_start_n = 1'b1;
                        tx_pid_n   = bus.ulpi_data_i[3:0];
                    end
                end
            end
            CMD_ACK: begin
                case (cmd_q[7:6])
                    2'b10: begin
                        state_n = REGW_DATA;
                        nxt_n   = 1'b1;
                    end
                    2'b11: begin
                        state_n = REGR_TURN;
                        dir_n   = 1'b1;
                    end
                    2'b01: begin
                        state_n = TX_DATA;
                        nxt_n   = 1'b1;
                    end
                    default: state_n = IDLE;
                endcase
            end
            REGW_DATA: begin
                wdata_n = bus.ulpi_data_i;
                state_n = REGW_STP;
            end
            REGW_STP: begin
                if (bus.ulpi_stp_i) begin
                    commit  = 1'b1;
                    state_n = IDLE;
                end
            end
            REGR_TURN: begin
                data_n  = rd_val;
                state_n = REGR_DATA;
            end
            REGR_DATA: begin
                dir_n   = 1'b0;
                state_n = TURN_BACK;
            end
            TX_DATA: begin
                if (bus.ulpi_stp_i) begin
                    tx_end_n   = 1'b1;
                    tx_abort_n = (bus.ulpi_data_i == 8'hFF);
                    state_n    = IDLE;
                end else begin
                    nxt_n      = 1'b1;
                    tx_data_n  = bus.ulpi_data_i;
                    tx_valid_n = 1'b1;
                end
            end
            RX_TURN, RX_DATA: begin
                if (state == RX_DATA && rx_done_q) begin
                    dir_n     = 1'b0;
                    rx_done_n = 1'b0;
                    state_n   = TURN_BACK;
                end else if (bus.rx_valid_i) begin
                    data_n    = bus.rx_data_i;
                    nxt_n     = 1'b1;
                    rx_done_n = bus.rx_last_i;
                    state_n   = RX_DATA;
                end else begin
                    data_n    = {1'b0, bus.id_i, 2'b01, bus.vbus_state_i, bus.linestate_i};
                    last_rx_n = cur_rx;
                    state_n   = RX_DATA;
                end
            end
            RXCMD_TURN: begin
                data_n    = {1'b0, bus.id_i, 2'b00, bus.vbus_state_i, bus.linestate_i};
                last_rx_n = cur_rx;
                state_n   = RXCMD_DATA;
            end
            RXCMD_DATA: begin
                dir_n   = 1'b0;
                state_n = TURN_BACK;
            end
            TURN_BACK: state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge ulpi_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            cmd_q      <= 8'h00;
            wdata_q    <= 8'h00;
            data_q     <= 8'h00;
            dir_q      <= 1'b0;
            nxt_q      <= 1'b0;
            tx_start_q <= 1'b0;
            tx_pid_q   <= 4'h0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            tx_end_q   <= 1'b0;
            tx_abort_q <= 1'b0;
            rx_done_q  <= 1'b0;
            last_rx_q  <= 5'd0;
        end else begin
            state      <= state_n;
            cmd_q      <= cmd_n;
            wdata_q    <= wdata_n;
            data_q     <= data_n;
            dir_q      <= dir_n;
            nxt_q      <= nxt_n;
            tx_start_q <= tx_start_n;
            tx_pid_q   <= tx_pid_n;
            tx_data_q  <= tx_data_n;
            tx_valid_q <= tx_valid_n;
            tx_end_q   <= tx_end_n;
            tx_abort_q <= tx_abort_n;
            rx_done_q  <= rx_done_n;
            last_rx_q  <= last_rx_n;
        end
    end

    always_ff @(posedge ulpi_clk_i or posedge rst_i) begin
        if (rst_i) begin
            func_q    <= 8'h41;
            iface_q   <= 8'h00;
            otg_q     <= 8'h06;
            scratch_q <= 8'h00;
        end else if (commit) begin
            case (cmd_q[5:0])
                6'h04:   func_q    <= wdata_q;
                6'h05:   func_q    <= func_q | wdata_q;
                6'h06:   func_q    <= func_q & ~wdata_q;
                6'h07:   iface_q   <= wdata_q;
                6'h08:   iface_q   <= iface_q | wdata_q;
                6'h09:   iface_q   <= iface_q & ~wdata_q;
                6'h0A:   otg_q     <= wdata_q;
                6'h0B:   otg_q     <= otg_q | wdata_q;
                6'h0C:   otg_q     <= otg_q & ~wdata_q;
                6'h16:   scratch_q <= wdata_q;
                6'h17:   scratch_q <= scratch_q | wdata_q;
                6'h18:   scratch_q <= scratch_q & ~wdata_q;
                default: ;
            endcase
        end else if (func_q[5]) begin
            // Function-control reset bit is a one-cycle strobe.
            func_q[5] <= 1'b0;
        end
    end

    assign bus.ulpi_data_o  = data_q;
    assign bus.ulpi_dir_o   = dir_q;
    assign bus.ulpi_nxt_o   = nxt_q;
    assign bus.tx_start_o   = tx_start_q;
    assign bus.tx_pid_o     = tx_pid_q;
    assign bus.tx_data_o    = tx_data_q;
    assign bus.tx_valid_o   = tx_valid_q;
    assign bus.tx_end_o     = tx_end_q;
    assign bus.tx_abort_o   = tx_abort_q;
    assign bus.rx_ready_o   = (state == RX_TURN) || (state == RX_DATA && !rx_done_q);
    assign bus.func_ctrl_o  = func_q;
    assign bus.iface_ctrl_o = iface_q;
    assign bus.otg_ctrl_o   = otg_q;
endmodule

// File: tb/tb_oup_ulpi_phy_responder.sv
// tb/tb_oup_ulpi_phy_responder.sv - randomized self-checking bench for the ULPI PHY responder
module tb_oup_ulpi_phy_responder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;

    logic [7:0] m_reg [4];
    logic [1:0] cur_ls = 2'd0;
    logic [1:0] cur_vbus = 2'd0;
    logic       cur_id = 1'b0;
    logic [7:0] pl [$];

    always #5 clk = ~clk;

    oup_ulpi_phy_responder_if bus();

    oup_ulpi_phy_responder #(.VENDOR_ID(16'h0424), .PRODUCT_ID(16'h0009)) dut (
        .ulpi_clk_i(clk),
        .rst_i     (rst),
        .bus       (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int grp(input int a);
        if (a >= 4 && a <= 12) return (a - 4) / 3;
        if (a >= 22 && a <= 24) return 3;
        return -1;
    endfunction

    function automatic logic [7:0] model_read(input int a);
        logic [31:0] ids;
        int g;
        ids = 32'h0009_0424;
        if (a < 4) return ids[8*a +: 8];
        g = grp(a);
        if (g < 0) return 8'h00;
        return m_reg[g];
    endfunction

    task automatic model_write(input int a, input logic [7:0] d);
        int g;
        int off;
        g = grp(a);
        if (g < 0) return;
        off = (a >= 22) ? a - 22 : (a - 4) % 3;
        if (off == 0) m_reg[g] = d;
        else if (off == 1) m_reg[g] = m_reg[g] | d;
        else m_reg[g] = m_reg[g] & ~d;
    endtask

    task automatic do_write(input logic [7:0] cmd, input logic [7:0] d);
        bus.ulpi_data_i = cmd;
        tick;
        total++; if (bus.ulpi_nxt_o !== 1'b1) begin bad++; $display("FAIL wr_nxt_k cmd=%h got=%b exp=1", cmd, bus.ulpi_nxt_o); end
        bus.ulpi_data_i = d;
        tick;
        total++; if (bus.ulpi_nxt_o !== 1'b1) begin bad++; $display("FAIL wr_nxt_k1 cmd=%h got=%b exp=1", cmd, bus.ulpi_nxt_o); end
        tick;
        total++; if (bus.ulpi_nxt_o !== 1'b0) begin bad++; $display("FAIL wr_nxt_k2 cmd=%h got=%b exp=0", cmd, bus.ulpi_nxt_o); end
        bus.ulpi_data_i = 8'h00;
        bus.ulpi_stp_i = 1'b1;
        tick;
        bus.ulpi_stp_i = 1'b0;
        model_write(int'(cmd[5:0]), d);
        total++; if (bus.func_ctrl_o !== m_reg[0]) begin bad++; $display("FAIL wr_func cmd=%h d=%h got=%h exp=%h", cmd, d, bus.func_ctrl_o, m_reg[0]); end
        total++; if (bus.iface_ctrl_o !== m_reg[1]) begin bad++; $display("FAIL wr_iface cmd=%h d=%h got=%h exp=%h", cmd, d, bus.iface_ctrl_o, m_reg[1]); end
        total++; if (bus.otg_ctrl_o !== m_reg[2]) begin bad++; $display("FAIL wr_otg cmd=%h d=%h got=%h exp=%h", cmd, d, bus.otg_ctrl_o, m_reg[2]); end
        tick;
        m_reg[0][5] = 1'b0;
        total++; if (bus.func_ctrl_o !== m_reg[0]) begin bad++; $display("FAIL wr_func_selfclr got=%h exp=%h", bus.func_ctrl_o, m_reg[0]); end
    endtask

    task automatic do_read(input logic [7:0] cmd);
        logic [7:0] exp_v;
        exp_v = model_read(int'(cmd[5:0]));
        bus.ulpi_data_i = cmd;
        tick;
        total++; if (bus.ulpi_nxt_o !== 1'b1 || bus.ulpi_dir_o !== 1'b0) begin bad++; $display("FAIL rd_ack cmd=%h nxt=%b dir=%b exp nxt=1 dir=0", cmd, bus.ulpi_nxt_o, bus.ulpi_dir_o); end
        bus.ulpi_data_i = 8'h00;
        tick;
        total++; if (bus.ulpi_dir_o !== 1'b1 || bus.ulpi_nxt_o !== 1'b0 || bus.ulpi_data_o !== 8'h00) begin bad++; $display("FAIL rd_turn cmd=%h dir=%b nxt=%b data=%h exp dir=1 nxt=0 data=00", cmd, bus.ulpi_dir_o, bus.ulpi_nxt_o, bus.ulpi_data_o); end
        tick;
        total++; if (bus.ulpi_dir_o !== 1'b1 || bus.ulpi_data_o !== exp_v) begin bad++; $display("FAIL rd_data cmd=%h dir=%b data=%h exp dir=1 data=%h", cmd, bus.ulpi_dir_o, bus.ulpi_data_o, exp_v); end
        tick;
        total++; if (bus.ulpi_dir_o !== 1'b0 || bus.ulpi_data_o !== 8'h00) begin bad++; $display("FAIL rd_release cmd=%h dir=%b data=%h exp dir=0 data=00", cmd, bus.ulpi_dir_o, bus.ulpi_data_o); end
        tick;
    endtask

    task automatic do_tx(input logic [3:0] pid, input logic [7:0] stp_data);
        logic exp_abort;
        exp_abort = (stp_data == 8'hFF);
        bus.ulpi_data_i = 8'h40 | {4'h0, pid};
        tick;
        total++; if (bus.tx_start_o !== 1'b1 || bus.tx_pid_o !== pid || bus.ulpi_nxt_o !== 1'b1) begin bad++; $display("FAIL tx_start start=%b pid=%h nxt=%b exp 1/%h/1", bus.tx_start_o, bus.tx_pid_o, bus.ulpi_nxt_o, pid); end
        bus.ulpi_data_i = 8'h00;
        tick;
        total++; if (bus.ulpi_nxt_o !== 1'b1 || bus.tx_start_o !== 1'b0) begin bad++; $display("FAIL tx_ack nxt=%b start=%b exp 1/0", bus.ulpi_nxt_o, bus.tx_start_o); end
        foreach (pl[i]) begin
            bus.ulpi_data_i = pl[i];
            tick;
            total++; if (bus.tx_valid_o !== 1'b1 || bus.tx_data_o !== pl[i] || bus.ulpi_nxt_o !== 1'b1) begin bad++; $display("FAIL tx_byte%0d valid=%b data=%h nxt=%b exp 1/%h/1", i, bus.tx_valid_o, bus.tx_data_o, bus.ulpi_nxt_o, pl[i]); end
        end
        bus.ulpi_data_i = stp_data;
        bus.ulpi_stp_i = 1'b1;
        tick;
        total++; if (bus.tx_end_o !== 1'b1 || bus.tx_abort_o !== exp_abort || bus.ulpi_nxt_o !== 1'b0 || bus.tx_valid_o !== 1'b0) begin bad++; $display("FAIL tx_end end=%b abort=%b nxt=%b valid=%b exp 1/%b/0/0", bus.tx_end_o, bus.tx_abort_o, bus.ulpi_nxt_o, bus.tx_valid_o, exp_abort); end
        bus.ulpi_stp_i = 1'b0;
        bus.ulpi_data_i = 8'h00;
        tick;
        total++; if (bus.tx_end_o !== 1'b0 || bus.tx_abort_o !== 1'b0) begin bad++; $display("FAIL tx_end_pulse end=%b abort=%b exp 0/0", bus.tx_end_o, bus.tx_abort_o); end
    endtask

    task automatic do_rxcmd(input logic [1:0] ls, input logic [1:0] vb, input logic id, input logic with_txcmd);
        logic [7:0] exp_b;
        cur_ls = ls; cur_vbus = vb; cur_id = id;
        exp_b = 8'(int'(id) * 64 + int'(vb) * 4 + int'(ls));
        bus.linestate_i = ls;
        bus.vbus_state_i = vb;
        bus.id_i = id;
        if (with_txcmd) bus.ulpi_data_i = 8'h84;
        tick;
        total++; if (bus.ulpi_dir_o !== 1'b1 || bus.ulpi_nxt_o !== 1'b0) begin bad++; $display("FAIL rxcmd_turn dir=%b nxt=%b exp 1/0", bus.ulpi_dir_o, bus.ulpi_nxt_o); end
        tick;
        total++; if (bus.ulpi_data_o !== exp_b || bus.ulpi_dir_o !== 1'b1 || bus.ulpi_nxt_o !== 1'b0) begin bad++; $display("FAIL rxcmd_byte data=%h dir=%b nxt=%b exp %h/1/0", bus.ulpi_data_o, bus.ulpi_dir_o, bus.ulpi_nxt_o, exp_b); end
        tick;
        total++; if (bus.ulpi_dir_o !== 1'b0 || bus.ulpi_data_o !== 8'h00 || bus.ulpi_nxt_o !== 1'b0) begin bad++; $display("FAIL rxcmd_release dir=%b data=%h nxt=%b exp 0/00/0", bus.ulpi_dir_o, bus.ulpi_data_o, bus.ulpi_nxt_o); end
        tick;
        total++; if (bus.ulpi_nxt_o !== 1'b0) begin bad++; $display("FAIL rxcmd_turnback_nxt got=%b exp=0", bus.ulpi_nxt_o); end
        if (with_txcmd) begin
            tick;
            total++; if (bus.ulpi_nxt_o !== 1'b1) begin bad++; $display("FAIL deferred_txcmd_nxt got=%b exp=1", bus.ulpi_nxt_o); end
            bus.ulpi_data_i = 8'h55;
            tick;
            tick;
            bus.ulpi_data_i = 8'h00;
            bus.ulpi_stp_i = 1'b1;
            tick;
            bus.ulpi_stp_i = 1'b0;
            model_write(4, 8'h55);
            total++; if (bus.func_ctrl_o !== m_reg[0]) begin bad++; $display("FAIL deferred_write func=%h exp=%h", bus.func_ctrl_o, m_reg[0]); end
        end
    endtask

    task automatic do_rx(input logic [15:0] gapmask);
        int i;
        int cyc;
        int n;
        logic gap;
        logic [7:0] ev_b;
        n = pl.size();
        ev_b = 8'(int'(cur_id) * 64 + 16 + int'(cur_vbus) * 4 + int'(cur_ls));
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i = pl[0];
        bus.rx_last_i = (n == 1);
        tick;
        total++; if (bus.ulpi_dir_o !== 1'b1 || bus.ulpi_nxt_o !== 1'b1 || bus.ulpi_data_o !== 8'h00 || bus.rx_ready_o !== 1'b1) begin bad++; $display("FAIL rx_turn dir=%b nxt=%b data=%h ready=%b exp 1/1/00/1", bus.ulpi_dir_o, bus.ulpi_nxt_o, bus.ulpi_data_o, bus.rx_ready_o); end
        i = 0;
        cyc = 0;
        while (i < n) begin
            gap = (i > 0) && (cyc < 16) && gapmask[cyc];
            cyc++;
            if (gap) begin
                bus.rx_valid_i = 1'b0;
                bus.rx_last_i = 1'b0;
            end else begin
                bus.rx_valid_i = 1'b1;
                bus.rx_data_i = pl[i];
                bus.rx_last_i = (i == n - 1);
            end
            tick;
            if (gap) begin
                total++; if (bus.ulpi_dir_o !== 1'b1 || bus.ulpi_nxt_o !== 1'b0 || bus.ulpi_data_o !== ev_b) begin bad++; $display("FAIL rx_gap_rxcmd dir=%b nxt=%b data=%h exp 1/0/%h", bus.ulpi_dir_o, bus.ulpi_nxt_o, bus.ulpi_data_o, ev_b); end
            end else begin
                total++; if (bus.ulpi_dir_o !== 1'b1 || bus.ulpi_nxt_o !== 1'b1 || bus.ulpi_data_o !== pl[i]) begin bad++; $display("FAIL rx_byte%0d dir=%b nxt=%b data=%h exp 1/1/%h", i, bus.ulpi_dir_o, bus.ulpi_nxt_o, bus.ulpi_data_o, pl[i]); end
                i++;
            end
        end
        bus.rx_valid_i = 1'b0;
        bus.rx_last_i = 1'b0;
        #1;
        total++; if (bus.rx_ready_o !== 1'b0) begin bad++; $display("FAIL rx_ready_after_last got=%b exp=0", bus.rx_ready_o); end
        tick;
        total++; if (bus.ulpi_dir_o !== 1'b0 || bus.ulpi_nxt_o !== 1'b0 || bus.ulpi_data_o !== 8'h00) begin bad++; $display("FAIL rx_release dir=%b nxt=%b data=%h exp 0/0/00", bus.ulpi_dir_o, bus.ulpi_nxt_o, bus.ulpi_data_o); end
        tick;
    endtask

    task automatic test_reset;
        m_reg[0] = 8'h41; m_reg[1] = 8'h00; m_reg[2] = 8'h06; m_reg[3] = 8'h00;
        #1 rst = 1'b1;
        #1;
        total++; if (bus.func_ctrl_o !== 8'h41 || bus.iface_ctrl_o !== 8'h00 || bus.otg_ctrl_o !== 8'h06) begin bad++; $display("FAIL reset_regs func=%h iface=%h otg=%h exp 41/00/06", bus.func_ctrl_o, bus.iface_ctrl_o, bus.otg_ctrl_o); end
        total++; if (bus.ulpi_dir_o !== 1'b0 || bus.ulpi_nxt_o !== 1'b0 || bus.ulpi_data_o !== 8'h00 || bus.rx_ready_o !== 1'b0) begin bad++; $display("FAIL reset_bus dir=%b nxt=%b data=%h ready=%b exp 0/0/00/0", bus.ulpi_dir_o, bus.ulpi_nxt_o, bus.ulpi_data_o, bus.rx_ready_o); end
        total++; if (bus.tx_start_o !== 1'b0 || bus.tx_valid_o !== 1'b0 || bus.tx_end_o !== 1'b0 || bus.tx_abort_o !== 1'b0 || bus.tx_pid_o !== 4'h0 || bus.tx_data_o !== 8'h00) begin bad++; $display("FAIL reset_tx start=%b valid=%b end=%b abort=%b pid=%h data=%h exp zeros", bus.tx_start_o, bus.tx_valid_o, bus.tx_end_o, bus.tx_abort_o, bus.tx_pid_o, bus.tx_data_o); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick;
        total++; if (bus.ulpi_dir_o !== 1'b0) begin bad++; $display("FAIL reset_no_rxcmd dir=%b exp=0", bus.ulpi_dir_o); end
    endtask

    task automatic test_reg_write;
        do_write(8'h84, 8'h55);
        do_write(8'h86, 8'h05);
        for (int k = 0; k < 16; k++) begin
            logic [5:0] a;
            a = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(4, 12));
            if ($urandom_range(0, 4) == 0) a = 6'($urandom_range(22, 24));
            do_write({2'b10, a}, 8'($urandom_range(0, 255)));
        end
    endtask

    task automatic test_reg_read;
        do_read(8'hC1);
        do_read(8'hC5);
        do_read(8'hE0);
        for (int k = 0; k < 12; k++) do_read({2'b11, 6'($urandom_range(0, 63))});
    endtask

    task automatic test_transmit;
        pl = '{8'h11, 8'h22, 8'h33};
        do_tx(4'h3, 8'h00);
        do_tx(4'h3, 8'hFF);
        pl.delete();
        do_tx(4'hA, 8'h00);
        for (int k = 0; k < 6; k++) begin
            pl.delete();
            for (int j = 0; j < int'($urandom_range(0, 5)); j++) pl.push_back(8'($urandom_range(0, 255)));
            do_tx(4'($urandom_range(0, 15)), ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom_range(0, 254)));
        end
    endtask

    task automatic test_rxcmd;
        do_rxcmd(2'b01, 2'b00, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            logic [1:0] nl;
            logic [1:0] nv;
            logic ni;
            nl = 2'($urandom_range(0, 3));
            nv = 2'($urandom_range(0, 3));
            ni = 1'($urandom_range(0, 1));
            if (nl == cur_ls && nv == cur_vbus && ni == cur_id) nl = nl ^ 2'b01;
            do_rxcmd(nl, nv, ni, 1'b0);
        end
    endtask

    task automatic test_rx_packet;
        pl = '{8'hC3, 8'hAA, 8'h55};
        do_rx(16'h0002);
        for (int k = 0; k < 6; k++) begin
            pl.delete();
            for (int j = 0; j < int'($urandom_range(1, 5)); j++) pl.push_back(8'($urandom_range(0, 255)));
            do_rx(16'($urandom_range(0, 65535)) & 16'h5A5A);
        end
    endtask

    task automatic test_reset_mid_write;
        bus.ulpi_data_i = 8'h84;
        tick;
        bus.ulpi_data_i = 8'h99;
        tick;
        tick;
        bus.ulpi_data_i = 8'h00;
        #2 rst = 1'b1;
        #1;
        m_reg[0] = 8'h41; m_reg[1] = 8'h00; m_reg[2] = 8'h06; m_reg[3] = 8'h00;
        total++; if (bus.func_ctrl_o !== 8'h41 || bus.iface_ctrl_o !== 8'h00 || bus.otg_ctrl_o !== 8'h06) begin bad++; $display("FAIL midrst_regs func=%h iface=%h otg=%h exp 41/00/06", bus.func_ctrl_o, bus.iface_ctrl_o, bus.otg_ctrl_o); end
        total++; if (bus.ulpi_dir_o !== 1'b0 || bus.ulpi_nxt_o !== 1'b0 || bus.ulpi_data_o !== 8'h00) begin bad++; $display("FAIL midrst_bus dir=%b nxt=%b data=%h exp 0/0/00", bus.ulpi_dir_o, bus.ulpi_nxt_o, bus.ulpi_data_o); end
        bus.linestate_i = 2'b00; bus.vbus_state_i = 2'b00; bus.id_i = 1'b0;
        cur_ls = 2'b00; cur_vbus = 2'b00; cur_id = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus.ulpi_stp_i = 1'b1;
        tick;
        bus.ulpi_stp_i = 1'b0;
        total++; if (bus.func_ctrl_o !== 8'h41) begin bad++; $display("FAIL midrst_no_commit func=%h exp=41", bus.func_ctrl_o); end
        tick;
        do_rxcmd(2'b11, 2'b01, 1'b1, 1'b0);
        do_read(8'hC4);
    endtask

    initial begin
        bus.ulpi_data_i = 8'h00;
        bus.ulpi_stp_i = 1'b0;
        bus.rx_data_i = 8'h00;
        bus.rx_valid_i = 1'b0;
        bus.rx_last_i = 1'b0;
        bus.linestate_i = 2'b00;
        bus.vbus_state_i = 2'b00;
        bus.id_i = 1'b0;
        test_reset;
        test_reg_write;
        test_reg_read;
        test_transmit;
        test_rxcmd;
        test_rx_packet;
        test_reset_mid_write;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
